// File: rtl/ysyx_040750_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_040750_pipe_pkg
// Shared definitions for the pipeline-stage register and its storage:
//   - default PC / instruction widths
//   - NOP payload used for killed instructions (addi x0,x0,0)
//   - entry field widths and layout {pc, inst, intr, bubble}
// ---------------------------------------------------------------------------
package ysyx_040750_pipe_pkg;

    localparam int PC_W_DEF   = 32;
    localparam int INST_W_DEF = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_DEF = 32'h00000013;

    // Control bits carried with every entry: intr tag + bubble flag
    localparam int INTR_W       = 1;
    localparam int BUBBLE_W     = 1;
    localparam int ENTRY_CTRL_W = INTR_W + BUBBLE_W;

    // Entry layout at default widths (MSB first: pc, inst, intr, bubble)
    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] inst;
        logic                  intr;
        logic                  bubble;
    } pipe_entry_t;

    // Packed width of one entry for arbitrary PC/instruction widths
    function automatic int entry_w(input int pc_w, input int inst_w);
        return pc_w + inst_w + ENTRY_CTRL_W;
    endfunction

endpackage

// File: rtl/ysyx_040750_pipe_fifo2.sv
// ---------------------------------------------------------------------------
// ysyx_040750_pipe_fifo2
// Generic 1- or 2-entry FIFO storage with pointers and occupancy count.
// No handshake logic lives here: the parent decides when to push/pop/clear.
//
// Ports:
//   I_sys_clk  clock
//   I_rst      synchronous active-high reset (clears entries, pointers, count)
//   i_clr      drop all entries (pointers/count to 0); a same-cycle push is
//              ignored, a same-cycle pop is harmless
//   i_push     write i_din at the write pointer
//   i_pop      advance the read pointer
//   i_din      entry to store
//   o_dout     head entry; holds the last head value while empty
//   o_count    occupied entries (0..DEPTH)
//
// DEPTH must be 1 or 2. The array is always two slots; with DEPTH = 1 the
// pointers never move so only slot 0 is used.
// ---------------------------------------------------------------------------
module ysyx_040750_pipe_fifo2
    import ysyx_040750_pipe_pkg::*;
#(
    parameter int W     = 66,
    parameter int DEPTH = 2
) (
    input  logic         I_sys_clk,
    input  logic         I_rst,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_count
);

    // Pointer increment: toggles for DEPTH = 2, stays at 0 for DEPTH = 1
    localparam logic PTR_STEP = (DEPTH == 2) ? 1'b1 : 1'b0;

    logic [W-1:0] r_mem [0:1];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic [W-1:0] r_hold;     // copy of the head, presented once empty

    // Storage, pointers, count and head-hold register
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            r_hold   <= '0;
        end else begin
            if (r_count != 2'd0) begin
                r_hold <= r_mem[r_rptr];
            end
            if (i_clr) begin
                r_wptr  <= 1'b0;
                r_rptr  <= 1'b0;
                r_count <= 2'd0;
            end else begin
                if (i_push) begin
                    r_mem[r_wptr] <= i_din;
                    r_wptr        <= r_wptr ^ PTR_STEP;
                end
                if (i_pop) begin
                    r_rptr <= r_rptr ^ PTR_STEP;
                end
                case ({i_push, i_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign o_dout  = (r_count != 2'd0) ? r_mem[r_rptr] : r_hold;
    assign o_count = r_count;

endmodule

// File: rtl/ysyx_040750_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// ysyx_040750_pipe_stage_reg
// Pipeline-stage register with valid/allowin handshake and a DEPTH-entry
// elastic buffer (1 = plain register, 2 = skid buffer).
//
// Ports:
//   I_sys_clk, I_rst        clock, synchronous active-high reset
//   I_valid / O_allowin     upstream handshake (fire_in = I_valid & O_allowin)
//   I_pc, I_inst, I_intr    incoming payload
//   I_kill                  turn the accepted (or next accepted) input into a
//                           NOP bubble; a kill without transfer is latched
//   I_flush                 drop every held entry and any same-cycle input
//   I_stall                 hide the head (O_valid = 0); input still accepted
//   I_allowout / O_valid    downstream handshake (fire_out = O_valid & I_allowout)
//   O_pc, O_inst, O_intr,
//   O_bubble                head entry
//   O_count                 occupied entries
//
// Optional feature, macro YSYX_040750_PIPE_STAGE_PERF_EN:
//   O_stall_cnt   cycles holding data without transferring it out (saturating)
//   O_bubble_cnt  killed inputs accepted (saturating)
// ---------------------------------------------------------------------------
module ysyx_040750_pipe_stage_reg
    import ysyx_040750_pipe_pkg::*;
#(
    parameter int                PC_W     = PC_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter int                DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input  logic              I_sys_clk,
    input  logic              I_rst,
    input  logic              I_valid,
    output logic              O_allowin,
    input  logic [PC_W-1:0]   I_pc,
    input  logic [INST_W-1:0] I_inst,
    input  logic              I_intr,
    input  logic              I_kill,
    input  logic              I_flush,
    input  logic              I_stall,
    input  logic              I_allowout,
    output logic              O_valid,
    output logic [PC_W-1:0]   O_pc,
    output logic [INST_W-1:0] O_inst,
    output logic              O_intr,
    output logic              O_bubble,
    output logic [1:0]        O_count
`ifdef YSYX_040750_PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       O_stall_cnt,
    output logic [31:0]       O_bubble_cnt
`endif
);

    localparam int         ENTRY_W = entry_w(PC_W, INST_W);
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic               r_kill_latch;
    logic               w_fire_in;
    logic               w_fire_out;
    logic               w_kill_eff;
    logic [ENTRY_W-1:0] w_entry_in;
    logic [ENTRY_W-1:0] w_entry_out;
    logic [1:0]         w_count;

    // Handshake is purely combinational on the stored count; there is no
    // path from I_valid to O_allowin, so no loop is formed with upstream.
    assign O_valid    = (w_count != 2'd0) & ~I_stall;
    assign w_fire_out = O_valid & I_allowout;
    assign O_allowin  = (w_count < DEPTH_C) | w_fire_out;
    assign w_fire_in  = I_valid & O_allowin;
    assign w_kill_eff = I_kill | r_kill_latch;

    // Build the entry to store: killed inputs keep their PC but lose payload
    always_comb begin
        w_entry_in = '0;
        if (w_kill_eff) begin
            w_entry_in = {I_pc, NOP_INST, 1'b0, 1'b1};
        end else begin
            w_entry_in = {I_pc, I_inst, I_intr, 1'b0};
        end
    end

    // Remember a kill that arrived while nothing was accepted
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_kill_latch <= 1'b0;
        end else if (I_flush) begin
            r_kill_latch <= 1'b0;
        end else if (w_fire_in) begin
            r_kill_latch <= 1'b0;
        end else if (I_kill) begin
            r_kill_latch <= 1'b1;
        end else begin
            r_kill_latch <= r_kill_latch;
        end
    end

    // Flush suppresses the push; the head may still leave this cycle
    ysyx_040750_pipe_fifo2 #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .I_sys_clk (I_sys_clk),
        .I_rst     (I_rst),
        .i_clr     (I_flush),
        .i_push    (w_fire_in & ~I_flush),
        .i_pop     (w_fire_out),
        .i_din     (w_entry_in),
        .o_dout    (w_entry_out),
        .o_count   (w_count)
    );

    assign {O_pc, O_inst, O_intr, O_bubble} = w_entry_out;
    assign O_count = w_count;

`ifdef YSYX_040750_PIPE_STAGE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Saturating performance counters
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if ((w_count != 2'd0) && !w_fire_out && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_fire_in && w_kill_eff && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign O_stall_cnt  = r_stall_cnt;
    assign O_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: doc/ysyx_040750_pipe_stage_reg.md
Name: ysyx_040750_pipe_stage_reg

Overview:
- Parametrised pipeline-stage register with a valid/allowin handshake, usable between any two stages (IF/ID, ID/EX, ...).
- Holds PC, instruction and interrupt tag in a DEPTH-entry elastic buffer (1 = plain register, 2 = skid buffer), so upstream need not stall for a one-cycle downstream back-pressure.
- Kill turns the entering instruction into a NOP bubble; flush drops all held entries.
- Kill requests arriving without a transfer are latched until the next accepted input.

Parameters:
- PC_W, 32, PC width.
- INST_W, 32, instruction width.
- DEPTH, 2, buffer entries; legal values 1 or 2.
- NOP_INST, 32'h00000013, payload substituted for killed instructions (addi x0,x0,0).

Ports:
- I_sys_clk  in  1  clock
- I_rst  in  1  synchronous active-high reset
- I_valid  in  1  upstream data valid
- O_allowin  out  1  stage can accept this cycle
- I_pc  in  PC_W  incoming PC
- I_inst  in  INST_W  incoming instruction
- I_intr  in  1  timer-interrupt tag for the incoming instruction
- I_kill  in  1  convert the accepted (or next accepted) input to a bubble
- I_flush  in  1  discard all held entries
- I_stall  in  1  hold head entry, output not valid
- I_allowout  in  1  downstream can accept
- O_valid  out  1  head entry presented downstream
- O_pc  out  PC_W  head PC
- O_inst  out  INST_W  head instruction
- O_intr  out  1  head interrupt tag
- O_bubble  out  1  head entry is an injected bubble
- O_count  out  2  occupied entries

Behaviour:
- Reset: I_rst and I_sys_clk as already decided. Count = 0, pointers = 0, kill latch = 0, and all entries = {0, 0, 0, 0}.
  - Outputs after reset: O_pc, O_inst, O_intr and O_bubble = 0; O_valid = 0; O_count = 0; O_allowin = 1.
- Handshake signals (all combinational, no registered outputs beyond storage):
  - fire_in = I_valid & O_allowin
  - O_valid = (count != 0) & ~I_stall
  - fire_out = O_valid & I_allowout
  - O_allowin = (count < DEPTH) | fire_out
- Latency: an entry accepted in cycle N is presented (O_valid = 1 if not stalled) in cycle N+1.
- Storage order: FIFO. Write pointer and read pointer are 1-bit with modulo-DEPTH wrap; both are unused when DEPTH = 1.
- Head output: O_* come from the entry at the read pointer. When count = 0, O_* hold the last head value.
- Kill handling:
  - Effective kill = I_kill | kill_latch.
  - On fire_in with effective kill, the stored entry is {I_pc, NOP_INST, intr = 0, bubble = 1}.
  - On fire_in without kill, the stored entry is {I_pc, I_inst, I_intr, 0}.
- Kill latch update:
  - Set when I_kill = 1 and fire_in = 0.
  - Cleared on fire_in.
  - Hold otherwise.
- Count update:
  - +1 on fire_in only; -1 on fire_out only.
  - Unchanged when both occur or neither occurs.
- Full (count = DEPTH):
  - O_allowin = fire_out.
  - Simultaneous in and out is legal; the buffer stays full.
- Empty: fire_out is impossible; an incoming entry is not bypassed combinationally.
- Flush, highest priority after reset:
  - Next count = 0, pointers = 0, kill latch = 0.
  - Any same-cycle fire_in is dropped.
  - The current head may still transfer this cycle if fire_out = 1; downstream sees it.
- Stall:
  - Forces O_valid = 0, which blocks fire_out.
  - Input is still accepted while count < DEPTH.
- DEPTH = 1: identical rules, so O_allowin = ~full | fire_out, matching the classic single-register stage.
- Mid-operation reset clears everything regardless of other inputs.

Optional Feature:
- Macro: YSYX_040750_PIPE_STAGE_PERF_EN.
- When defined, adds these outputs, each cleared by reset and saturating at all-ones:
  - O_stall_cnt [31:0]: increments each cycle count != 0 & ~fire_out.
  - O_bubble_cnt [31:0]: increments on each killed fire_in.
- When undefined: no ports and no counters; behaviour is otherwise identical.

Decomposition:
- Shared package ysyx_040750_pipe_pkg:
  - NOP_INST constant.
  - Default PC_W and INST_W.
  - Entry struct/field-width localparams {pc, inst, intr, bubble}.
- Sub-module ysyx_040750_pipe_fifo2:
  - Generic 1/2-entry storage with pointers and count.
  - Parent keeps the handshake, kill latch, flush priority and perf counters.

Test Plan:
1. Reset, then I_valid = 1, pc = 0x80000000, inst = 0x00100093, I_allowout = 1 -> next cycle O_valid = 1, O_pc = 0x80000000, O_inst = 0x00100093, O_bubble = 0.
2. DEPTH = 2, I_allowout = 0, push pc 0x80000000 and 0x80000004 -> O_count = 2, O_allowin = 0. Raise I_allowout -> O_allowin = 1 same cycle; outputs arrive in order 0x80000000 then 0x80000004.
3. I_kill = 1 with fire_in, inst 0x00000513, I_intr = 1 -> stored O_inst = 0x00000013, O_intr = 0, O_bubble = 1.
4. I_kill pulse while I_valid = 0, then accept pc 0x80000010 two cycles later -> that entry is a bubble (O_inst = 0x00000013); the following entry is normal.
5. Buffer full (2 entries), I_flush = 1 with I_valid = 1 -> next cycle O_count = 0, O_valid = 0; the flushed-cycle input never appears.
6. I_stall = 1 with count = 1 and I_valid = 1 -> O_valid = 0, entry accepted, O_count = 2. Release stall -> both entries drain in order.
